// File: rtl/xor_operand_feeder.sv
// Operand feeder for a 64-bit XOR datapath: two buffered input streams, pairing, and a registered output stage.
// Optional pair counter port beat_cnt is enabled by defining XOR_FEED_BEAT_CNT_EN.

module XorFeedFifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    cnt_d   = cnt_q;
    if (push_i) wrPtr_d = wrPtr_q + 1'b1;
    if (pop_i)  rdPtr_d = rdPtr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      cnt_q   <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wrPtr_q] <= data_i;
  end

  assign head_o  = mem_q[rdPtr_q];
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

module xor_operand_feeder #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_valid,
  output logic              b_ready,
  output logic [DATA_W-1:0] xa,
  output logic [DATA_W-1:0] xb,
  input  logic [DATA_W-1:0] xc,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef XOR_FEED_BEAT_CNT_EN
  ,
  output logic [31:0]       beat_cnt
`endif
);

  logic fullA, emptyA, fullB, emptyB;
  logic pushA, pushB, fire;
  logic              outValid_q, outValid_d;
  logic [DATA_W-1:0] outData_q, outData_d;

  // Ready ignores a same-cycle pop, which keeps it off the output-stall path.
  assign a_ready = !rst && !fullA;
  assign b_ready = !rst && !fullB;
  assign pushA   = a_valid && a_ready;
  assign pushB   = b_valid && b_ready;
  assign fire    = !emptyA && !emptyB && (!outValid_q || out_ready);

  XorFeedFifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) uFifoA (
    .clk(clk), .rst(rst), .push_i(pushA), .pop_i(fire), .data_i(a_data),
    .head_o(xa), .full_o(fullA), .empty_o(emptyA)
  );

  XorFeedFifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) uFifoB (
    .clk(clk), .rst(rst), .push_i(pushB), .pop_i(fire), .data_i(b_data),
    .head_o(xb), .full_o(fullB), .empty_o(emptyB)
  );

  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    if (fire) begin
      outValid_d = 1'b1;
      outData_d  = xc;
    end else if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
    end else begin
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;

`ifdef XOR_FEED_BEAT_CNT_EN
  logic [31:0] beatCnt_q;

  always_ff @(posedge clk) begin
    if (rst)       beatCnt_q <= '0;
    else if (fire) beatCnt_q <= beatCnt_q + 32'd1;
  end

  assign beat_cnt = beatCnt_q;
`endif

endmodule

// File: tb/tb_xor_operand_feeder.sv
// Self-checking bench for xor_operand_feeder: queue-based reference model, directed scenarios and random traffic.
// Build with XOR_FEED_BEAT_CNT_EN defined to also check the pair counter.

module tb_xor_operand_feeder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] a_data, b_data;
  logic        a_valid, b_valid, out_ready;
  logic        a_ready, b_ready, out_valid;
  logic [63:0] xa, xb, xc, out_data;
`ifdef XOR_FEED_BEAT_CNT_EN
  logic [31:0] beat_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [63:0] qA[$];
  logic [63:0] qB[$];
  logic [63:0] cap[$];
  bit          mValid;
  logic [63:0] mData;
  int unsigned mBeat;

  always #5 clk = ~clk;

  // The XOR datapath this block feeds.
  assign xc = xa ^ xb;

  xor_operand_feeder #(.DATA_W(64), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .xa(xa), .xb(xb), .xc(xc),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef XOR_FEED_BEAT_CNT_EN
    , .beat_cnt(beat_cnt)
`endif
  );

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Every cycle: DUT outputs against the queue model's view of the current state.
  task automatic checkOutput();
    compare("a_ready", 64'(a_ready), 64'(!rst && qA.size() < DEPTH));
    compare("b_ready", 64'(b_ready), 64'(!rst && qB.size() < DEPTH));
    compare("out_valid", 64'(out_valid), 64'(mValid));
    compare("out_data", out_data, mData);
    if (qA.size() > 0) compare("xa_head", xa, qA[0]);
    if (qB.size() > 0) compare("xb_head", xb, qB[0]);
`ifdef XOR_FEED_BEAT_CNT_EN
    compare("beat_cnt", 64'(beat_cnt), 64'(mBeat));
`endif
  endtask

  // Check the current cycle, drive the next one, advance the model by one clock.
  task automatic applyStimulus(input bit r, input bit av, input logic [63:0] ad,
                               input bit bv, input logic [63:0] bd, input bit ordy);
    bit pushA, pushB, fire;
    logic [63:0] ha, hb;
    checkOutput();
    rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
    if (r) begin
      qA.delete(); qB.delete();
      mValid = 1'b0; mData = '0; mBeat = 0;
    end else begin
      pushA = av && (qA.size() < DEPTH);
      pushB = bv && (qB.size() < DEPTH);
      fire  = (qA.size() > 0) && (qB.size() > 0) && (!mValid || ordy);
      if (fire) begin
        ha = qA.pop_front();
        hb = qB.pop_front();
        mData  = ha ^ hb;
        mValid = 1'b1;
        mBeat++;
      end else if (mValid && ordy) begin
        mValid = 1'b0;
      end
      if (pushA) qA.push_back(ad);
      if (pushB) qB.push_back(bd);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, ordy);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
  endtask

  initial begin
    int pA, pB, pR;
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    a_data = '0; b_data = '0;
    mValid = 1'b0; mData = '0; mBeat = 0;
    @(posedge clk);
    @(negedge clk);

    compare("reset_out_valid", 64'(out_valid), 64'd0);
    compare("reset_out_data", out_data, 64'd0);
    compare("reset_a_ready", 64'(a_ready), 64'd0);

    // T1: single pair latency
    doReset();
    idle(1'b1);
    applyStimulus(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1);
    compare("t1_valid_n1", 64'(out_valid), 64'd0);
    idle(1'b1);
    compare("t1_valid_n2", 64'(out_valid), 64'd1);
    compare("t1_data_n2", out_data, 64'hF0F0_F0F0_F0F0_F0F0);
    idle(1'b1);
    compare("t1_valid_n3", 64'(out_valid), 64'd0);
`ifdef XOR_FEED_BEAT_CNT_EN
    compare("t1_beat_cnt", 64'(beat_cnt), 64'd1);
`endif

    // T2: A fills alone, then B drains it in order
    for (int k = 1; k <= 4; k++) applyStimulus(1'b0, 1'b1, 64'(k), 1'b0, 64'd0, 1'b1);
    compare("t2_a_ready_full", 64'(a_ready), 64'd0);
    compare("t2_no_output", 64'(out_valid), 64'd0);
    cap.delete();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b0, 64'd0, (k < 4), 64'd1, 1'b1);
      if (out_valid) cap.push_back(out_data);
    end
    compare("t2_count", 64'(cap.size()), 64'd4);
    if (cap.size() == 4) begin
      compare("t2_r0", cap[0], 64'd0);
      compare("t2_r1", cap[1], 64'd3);
      compare("t2_r2", cap[2], 64'd2);
      compare("t2_r3", cap[3], 64'd5);
    end

    // T3: output stall fills both FIFOs, then drains
    for (int k = 0; k < 12; k++)
      applyStimulus(1'b0, 1'b1, {$urandom, $urandom}, 1'b1, {$urandom, $urandom}, 1'b0);
    compare("t3_a_ready_stall", 64'(a_ready), 64'd0);
    compare("t3_b_ready_stall", 64'(b_ready), 64'd0);
    compare("t3_valid_held", 64'(out_valid), 64'd1);
    for (int k = 0; k < 8; k++) idle(1'b1);
    compare("t3_drained", 64'(out_valid), 64'd0);

    // T4: reset with buffered beats and a pending result
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b0, 1'b1, 64'(k + 10), (k < 2), 64'(k + 20), 1'b0);
    compare("t4_pending", 64'(out_valid), 64'd1);
    applyStimulus(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
    compare("t4_rst_valid", 64'(out_valid), 64'd0);
    compare("t4_rst_data", out_data, 64'd0);
    idle(1'b1);
    applyStimulus(1'b0, 1'b1, 64'd5, 1'b1, 64'd6, 1'b1);
    idle(1'b1);
    compare("t4_refeed", out_data, 64'd3);
    idle(1'b1);
    compare("t4_no_stale", 64'(out_valid), 64'd0);

    // T5: hold both FIFOs at two entries with push and pop every cycle
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b0, 1'b1, {$urandom, $urandom}, 1'b1, {$urandom, $urandom}, 1'b0);
    for (int k = 0; k < 10; k++)
      applyStimulus(1'b0, 1'b1, {$urandom, $urandom}, 1'b1, {$urandom, $urandom}, 1'b1);
    compare("t5_depth_a", 64'(qA.size()), 64'd2);
    compare("t5_a_ready", 64'(a_ready), 64'd1);
    for (int k = 0; k < 6; k++) idle(1'b1);

    // Random traffic with shifting valid/ready densities and rare resets
    pA = 50; pB = 50; pR = 50;
    for (int k = 0; k < 3000; k++) begin
      if (k % 100 == 0) begin
        pA = $urandom_range(5, 100);
        pB = $urandom_range(5, 100);
        pR = $urandom_range(0, 100);
      end
      applyStimulus(($urandom_range(0, 299) == 0),
                    ($urandom_range(1, 100) <= pA), {$urandom, $urandom},
                    ($urandom_range(1, 100) <= pB), {$urandom, $urandom},
                    ($urandom_range(1, 100) <= pR));
    end
    checkOutput();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
